pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
- Program-counter stage for the monocycle CPU. It sits directly upstream of the instruction memory and drives its 32-bit word-indexed pc_addr.
- Each cycle it selects the next PC from one of: sequential, beq/bne branch, j/jal, jr, halt, or (optionally) exception entry/eret.
- It exports pc_plus1 for jal link-writeback and a valid flag for the decode/control stage.

Parameters:
- RESET_PC, 32'd0: PC loaded on reset, as a word index.
- EXC_VECTOR, 32'd64: exception entry word index; used only with PC_EXC_EN.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold PC; no state change except halt/reset.
- branch_taken  in  1  beq/bne condition resolved true this cycle.
- branch_offset  in  16  signed word offset (inst imm16).
- jump  in  1  j/jal this cycle.
- jump_target  in  26  inst[25:0].
- jump_reg  in  1  jr this cycle.
- reg_target  in  32  rs value for jr.
- halt_req  in  1  request to stop fetching.
- exc_req  in  1  exception/syscall entry (PC_EXC_EN only).
- eret  in  1  return from exception (PC_EXC_EN only).
- pc_addr  out  32  current PC, feeds instruction memory.
- pc_plus1  out  32  pc_addr+1, combinational.
- pc_valid  out  1  pc_addr holds a fetchable instruction.
- epc  out  32  saved exception PC; 0 without PC_EXC_EN.

Behaviour:
- Addressing is in words: next sequential PC = pc_addr+1. All arithmetic is modulo 2^32, so 32'hFFFF_FFFF+1 wraps to 0.
- Branch target = pc_plus1 + sign_extend(branch_offset). Offset 16'hFFFF yields pc_addr, i.e. a self-loop.
- Jump target = {pc_plus1[31:26], jump_target}. jr target = reg_target, unmodified.
- FSM states: BOOT, RUN, HALT.
- Reset (rst=1 at edge), from any state including mid-branch or HALT: state<=BOOT, pc_addr<=RESET_PC, epc<=0, pc_valid=0.
- BOOT: holds for exactly one cycle with pc_valid=0, then -> RUN. The PC does not advance.
- RUN: pc_valid=1. PC update priority, highest first: halt_req > stall > exc_req > eret > jump_reg > jump > branch_taken > sequential.
- halt_req in RUN: -> HALT next edge, pc_addr unchanged. halt_req wins even when stall is asserted.
- stall: pc_addr holds. exc_req, eret, and all branch/jump inputs are ignored that cycle, not queued.
- HALT: pc_valid=0, pc_addr frozen. Only rst exits HALT; all other inputs are ignored.
- Simultaneous jump and branch_taken: jump wins. Simultaneous jump_reg and jump: jump_reg wins.
- Latency: a redirect asserted in cycle N appears on pc_addr in cycle N+1. There are no delay slots.
- pc_valid is registered, derived from state. pc_plus1 is combinational from pc_addr.

Optional Feature:
- Macro PC_EXC_EN.
- Defined, exc_req (RUN, not stalled): epc<=pc_addr, pc_addr<=EXC_VECTOR.
- Defined, eret: pc_addr<=epc, epc unchanged.
- Defined, exc_req and eret together: exc_req wins and epc is overwritten.
- Not defined: exc_req and eret ports stay present but are ignored; epc is tied to 32'd0. Benches stay uniform across builds.

Decomposition:
- Package pc_pkg holds:
  - FSM state encoding (BOOT=2'd0, RUN=2'd1, HALT=2'd2);
  - next-PC select enum (SEL_SEQ, SEL_BR, SEL_J, SEL_JR, SEL_EXC, SEL_ERET, SEL_HOLD);
  - default RESET_PC/EXC_VECTOR constants.
- One combinational sub-module, pc_next_mux, computes target arithmetic and the priority select.
- The top level holds the FSM, pc and epc registers.

Test Plan:
- Reset, then free-run: pc_valid=0 for 1 cycle after reset release, then pc_addr = 0,1,2,3… with pc_valid=1.
- At pc=5, branch_taken=1 with offset=16'hFFFC: next pc = 6-4 = 2. With offset=16'hFFFF: pc stays 5.
- At pc=10, jump=1, jump_target=26'd100, and branch_taken=1 in the same cycle: next pc=100. Then jump_reg=1, reg_target=32'h40 together with jump=1: next pc=0x40.
- stall held for 3 cycles at pc=7 while branch_taken=1: pc stays 7 throughout. After stall drops, pc=8 because the branch is not queued.
- halt_req at pc=12: pc_valid=0, pc frozen at 12 for 10 cycles. Then rst: pc=RESET_PC and BOOT, then RUN.
- With PC_EXC_EN, exc_req at pc=20: pc=64, epc=20. Then eret: pc=20. Without the macro, the same stimulus gives pc=21, 22 and epc=0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter fetch stage.
// Holds the FSM state encoding, the next-PC source select and the
// default reset / exception-entry word indices.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_t;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_J,
    SEL_JR,
    SEL_EXC,
    SEL_ERET,
    SEL_HOLD
  } pc_sel_t;

  localparam logic [31:0] DEFAULT_RESET_PC   = 32'd0;
  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'd64;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC selection and target arithmetic for the fetch stage.
// All addresses are word indices; arithmetic wraps modulo 2^32.
// Build option PC_EXC_EN enables the exception-entry and eret sources;
// without it exc_req/eret are accepted but never selected.
module pc_next_mux
  import pc_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
  input  logic [31:0] pc,
  input  logic [31:0] epc,
  input  logic        stall,
  input  logic        halt_req,
  input  logic        exc_req,
  input  logic        eret,
  input  logic        jump_reg,
  input  logic        jump,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic [25:0] jump_target,
  input  logic [31:0] reg_target,
  output logic [31:0] pc_plus1,
  output logic [31:0] next_pc,
  output pc_sel_t     sel
);

  logic [31:0] branch_pc;
  logic [31:0] jump_pc;

  assign pc_plus1  = pc + 32'd1;
  assign branch_pc = pc_plus1 + {{16{branch_offset[15]}}, branch_offset};
  assign jump_pc   = {pc_plus1[31:26], jump_target};

`ifndef PC_EXC_EN
  // Exception inputs and the saved PC have no effect in this build.
  logic unused_exc;
  assign unused_exc = exc_req ^ eret ^ (^epc) ^ (^EXC_VECTOR);
`endif

  // Priority select: halt/stall freeze the PC, then exceptions, then
  // jr over j over a taken branch, otherwise fall through sequentially.
  always_comb begin
    sel = SEL_SEQ;
    if (halt_req || stall) begin
      sel = SEL_HOLD;
    end
`ifdef PC_EXC_EN
    else if (exc_req) begin
      sel = SEL_EXC;
    end else if (eret) begin
      sel = SEL_ERET;
    end
`endif
    else if (jump_reg) begin
      sel = SEL_JR;
    end else if (jump) begin
      sel = SEL_J;
    end else if (branch_taken) begin
      sel = SEL_BR;
    end
  end

  // Turn the chosen source into the address loaded at the next edge.
  always_comb begin
    next_pc = pc_plus1;
    case (sel)
      SEL_BR:   next_pc = branch_pc;
      SEL_J:    next_pc = jump_pc;
      SEL_JR:   next_pc = reg_target;
`ifdef PC_EXC_EN
      SEL_EXC:  next_pc = EXC_VECTOR;
      SEL_ERET: next_pc = epc;
`endif
      SEL_HOLD: next_pc = pc;
      default:  next_pc = pc_plus1;
    endcase
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program-counter stage feeding the instruction memory of the monocycle CPU.
// Holds the BOOT/RUN/HALT sequencer, the PC register and the saved
// exception PC. Build option PC_EXC_EN enables exception entry and eret;
// without it epc is constant zero.
module pc_fetch_ctrl
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        jump_reg,
  input  logic [31:0] reg_target,
  input  logic        halt_req,
  input  logic        exc_req,
  input  logic        eret,
  output logic [31:0] pc_addr,
  output logic [31:0] pc_plus1,
  output logic        pc_valid,
  output logic [31:0] epc
);

  pc_state_t   state;
  pc_sel_t     sel;
  logic [31:0] next_pc;

  pc_next_mux #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_next_mux (
    .pc            (pc_addr),
    .epc           (epc),
    .stall         (stall),
    .halt_req      (halt_req),
    .exc_req       (exc_req),
    .eret          (eret),
    .jump_reg      (jump_reg),
    .jump          (jump),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump_target   (jump_target),
    .reg_target    (reg_target),
    .pc_plus1      (pc_plus1),
    .next_pc       (next_pc),
    .sel           (sel)
  );

  // Sequencer and PC register: BOOT lasts one cycle, RUN advances the PC,
  // HALT freezes everything until reset. pc_valid follows the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= BOOT;
      pc_addr  <= RESET_PC;
      pc_valid <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state    <= RUN;
          pc_valid <= 1'b1;
        end
        RUN: begin
          if (halt_req) begin
            state    <= HALT;
            pc_valid <= 1'b0;
          end else begin
            pc_addr  <= next_pc;
            pc_valid <= 1'b1;
          end
        end
        HALT: begin
          pc_valid <= 1'b0;
        end
        default: begin
          state    <= BOOT;
          pc_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef PC_EXC_EN
  // Capture the interrupted PC when exception entry is taken in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      epc <= 32'd0;
    end else if (state == RUN && sel == SEL_EXC) begin
      epc <= pc_addr;
    end
  end
`else
  logic unused_sel;
  assign unused_sel = (sel == SEL_EXC);
  assign epc        = 32'd0;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the
// PC rules. Honours PC_EXC_EN the same way as the design.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        jump;
  logic [25:0] jump_target;
  logic        jump_reg;
  logic [31:0] reg_target;
  logic        halt_req;
  logic        exc_req;
  logic        eret;
  logic [31:0] pc_addr;
  logic [31:0] pc_plus1;
  logic        pc_valid;
  logic [31:0] epc;

  int tests_run    = 0;
  int tests_failed = 0;

  // Behavioural model state
  logic [31:0] m_pc;
  logic [31:0] m_epc;
  logic        m_valid;
  bit          m_booting;
  bit          m_halted;

  pc_fetch_ctrl #(
    .RESET_PC   (32'd0),
    .EXC_VECTOR (32'd64)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_target   (jump_target),
    .jump_reg      (jump_reg),
    .reg_target    (reg_target),
    .halt_req      (halt_req),
    .exc_req       (exc_req),
    .eret          (eret),
    .pc_addr       (pc_addr),
    .pc_plus1      (pc_plus1),
    .pc_valid      (pc_valid),
    .epc           (epc)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic clearInputs();
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_offset = 16'd0;
    jump          = 1'b0;
    jump_target   = 26'd0;
    jump_reg      = 1'b0;
    reg_target    = 32'd0;
    halt_req      = 1'b0;
    exc_req       = 1'b0;
    eret          = 1'b0;
  endtask

  // Apply the PC rules to the model for one rising edge.
  task automatic modelStep();
    logic [31:0] seq;
    seq = m_pc + 32'd1;
    if (rst) begin
      m_pc      = 32'd0;
      m_epc     = 32'd0;
      m_valid   = 1'b0;
      m_booting = 1'b1;
      m_halted  = 1'b0;
    end else if (m_halted) begin
      m_valid = 1'b0;
    end else if (m_booting) begin
      m_booting = 1'b0;
      m_valid   = 1'b1;
    end else if (halt_req) begin
      m_halted = 1'b1;
      m_valid  = 1'b0;
    end else if (stall) begin
      m_valid = 1'b1;
    end
`ifdef PC_EXC_EN
    else if (exc_req) begin
      m_epc = m_pc;
      m_pc  = 32'd64;
    end else if (eret) begin
      m_pc = m_epc;
    end
`endif
    else if (jump_reg) begin
      m_pc = reg_target;
    end else if (jump) begin
      m_pc = {seq[31:26], jump_target};
    end else if (branch_taken) begin
      m_pc = seq + 32'(signed'(branch_offset));
    end else begin
      m_pc = seq;
    end
  endtask

  // One clock: edge, model update, then compare all outputs mid-cycle.
  task automatic applyStimulus(input string tag);
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkOutput({tag, "_pc"}, pc_addr, m_pc);
    checkOutput({tag, "_pc_plus1"}, pc_plus1, m_pc + 32'd1);
    checkOutput({tag, "_valid"}, {31'd0, pc_valid}, {31'd0, m_valid});
    checkOutput({tag, "_epc"}, epc, m_epc);
  endtask

  task automatic jumpTo(input logic [31:0] target);
    clearInputs();
    jump_reg   = 1'b1;
    reg_target = target;
    applyStimulus("jr_setup");
    clearInputs();
  endtask

  initial begin
    clearInputs();
    rst       = 1'b1;
    m_pc      = 32'd0;
    m_epc     = 32'd0;
    m_valid   = 1'b0;
    m_booting = 1'b1;
    m_halted  = 1'b0;

    // Reset state
    applyStimulus("reset");
    applyStimulus("reset");
    checkOutput("reset_valid_const", {31'd0, pc_valid}, 32'd0);

    // BOOT exits to RUN; PC has not moved yet
    rst = 1'b0;
    applyStimulus("boot_exit");
    checkOutput("boot_exit_pc_const", pc_addr, 32'd0);
    for (int i = 0; i < 5; i++) applyStimulus("free_run");
    checkOutput("free_run_pc_const", pc_addr, 32'd5);

    // Backward branch and self-loop
    branch_taken  = 1'b1;
    branch_offset = 16'hFFFC;
    applyStimulus("br_back");
    checkOutput("br_back_const", pc_addr, 32'd2);
    clearInputs();
    for (int i = 0; i < 3; i++) applyStimulus("seq");
    branch_taken  = 1'b1;
    branch_offset = 16'hFFFF;
    applyStimulus("br_self");
    checkOutput("br_self_const", pc_addr, 32'd5);

    // Jump beats branch, jr beats jump
    jumpTo(32'd10);
    jump          = 1'b1;
    jump_target   = 26'd100;
    branch_taken  = 1'b1;
    branch_offset = 16'd3;
    applyStimulus("j_over_br");
    checkOutput("j_over_br_const", pc_addr, 32'd100);
    clearInputs();
    jump_reg    = 1'b1;
    reg_target  = 32'h40;
    jump        = 1'b1;
    jump_target = 26'd5;
    applyStimulus("jr_over_j");
    checkOutput("jr_over_j_const", pc_addr, 32'h40);

    // Stall drops a concurrent branch
    jumpTo(32'd7);
    stall         = 1'b1;
    branch_taken  = 1'b1;
    branch_offset = 16'd20;
    for (int i = 0; i < 3; i++) begin
      applyStimulus("stall");
      checkOutput("stall_const", pc_addr, 32'd7);
    end
    clearInputs();
    applyStimulus("stall_release");
    checkOutput("stall_release_const", pc_addr, 32'd8);

    // Exception entry and return
    jumpTo(32'd20);
    exc_req = 1'b1;
    eret    = 1'b1;
    applyStimulus("exc");
    clearInputs();
    eret = 1'b1;
    applyStimulus("eret");
    clearInputs();
`ifdef PC_EXC_EN
    checkOutput("eret_const", pc_addr, 32'd20);
`else
    checkOutput("eret_const", pc_addr, 32'd22);
`endif

    // Wrap-around at the top of the address space
    jumpTo(32'hFFFF_FFFF);
    checkOutput("wrap_plus1_const", pc_plus1, 32'd0);
    applyStimulus("wrap");

    // Halt wins over stall, then only reset escapes
    jumpTo(32'd12);
    halt_req = 1'b1;
    stall    = 1'b1;
    applyStimulus("halt");
    for (int i = 0; i < 10; i++) begin
      stall         = 1'($urandom);
      branch_taken  = 1'($urandom);
      branch_offset = 16'($urandom);
      jump          = 1'($urandom);
      jump_target   = 26'($urandom);
      jump_reg      = 1'($urandom);
      reg_target    = $urandom;
      halt_req      = 1'($urandom);
      exc_req       = 1'($urandom);
      eret          = 1'($urandom);
      applyStimulus("halted");
      checkOutput("halted_pc_const", pc_addr, 32'd12);
    end
    clearInputs();
    rst = 1'b1;
    applyStimulus("halt_reset");
    rst = 1'b0;
    applyStimulus("halt_boot_exit");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst           = ($urandom_range(0, 39) == 0);
      halt_req      = ($urandom_range(0, 29) == 0);
      stall         = ($urandom_range(0, 4) == 0);
      exc_req       = ($urandom_range(0, 7) == 0);
      eret          = ($urandom_range(0, 7) == 0);
      jump_reg      = ($urandom_range(0, 5) == 0);
      jump          = ($urandom_range(0, 4) == 0);
      branch_taken  = ($urandom_range(0, 3) == 0);
      branch_offset = 16'($urandom);
      jump_target   = 26'($urandom);
      reg_target    = $urandom;
      applyStimulus("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
